// File: rtl/qnigma_mac_tx.sv
// qnigma_mac_tx: byte-wide Ethernet MAC transmitter for a GMII-style PHY.
// Prepends the preamble and SFD, streams the payload, appends the CRC32 FCS
// and enforces the inter-frame gap. Upstream underruns abort the frame.
// Optional feature macro: QNIGMA_MAC_TX_PAD_EN
//   defined   -> short frames are zero-padded to 60 bytes before the FCS
//   undefined -> no PAD state; short frames go out unpadded
// All PHY-side outputs are registered, so each byte appears on phy_dat one
// cycle after the state that produced it.
module qnigma_mac_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_dat,
    input  logic       in_val,
    input  logic       in_lst,
    output logic       in_rdy,
    output logic [7:0] phy_dat,
    output logic       phy_val,
    output logic       busy,
    output logic       err
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [3:0]  PRE_LAST = 4'd6;
    localparam logic [3:0]  FCS_LAST = 4'd3;
    // The IFG state runs 11 cycles; the IDLE cycle that follows (which is
    // where the next frame's in_val is seen) is the twelfth idle line cycle,
    // so back-to-back frames are separated by exactly 12 phy_val=0 cycles.
    localparam logic [3:0]  IFG_LAST = 4'd10;
    localparam logic [5:0]  MIN_LEN  = 6'd60;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_SFD  = 3'd2,
        S_PAY  = 3'd3,
`ifdef QNIGMA_MAC_TX_PAD_EN
        S_PAD  = 3'd4,
`endif
        S_FCS  = 3'd5,
        S_IFG  = 3'd6,
        S_DROP = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;     // phase counter: PRE, FCS and IFG
    logic [5:0]  len_q,   len_d;     // payload + pad byte count, saturating
    logic [31:0] crc_q,   crc_d;
    logic [7:0]  phy_dat_q, phy_dat_d;
    logic        phy_val_q, phy_val_d;
    logic        err_q,     err_d;
    logic [5:0]  len_inc;
    logic [31:0] fcs;

    // Reflected CRC32, LSB of the data byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign len_inc = (len_q >= MIN_LEN) ? MIN_LEN : len_q + 6'd1;
    assign fcs     = ~crc_q;
    assign busy    = (state_q != S_IDLE);
    assign phy_dat = phy_dat_q;
    assign phy_val = phy_val_q;
    assign err     = err_q;

    // State register and registered PHY outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            crc_q     <= '1;
            phy_dat_q <= '0;
            phy_val_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            crc_q     <= crc_d;
            phy_dat_q <= phy_dat_d;
            phy_val_q <= phy_val_d;
            err_q     <= err_d;
        end
    end

    // Next-state, datapath updates and in_rdy decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        crc_d     = crc_q;
        phy_dat_d = '0;
        phy_val_d = 1'b0;
        err_d     = 1'b0;
        in_rdy    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // First byte stays held upstream until PAY.
                if (in_val) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                end
            end

            S_PRE: begin
                phy_dat_d = PRE_BYTE;
                phy_val_d = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_SFD: begin
                phy_dat_d = SFD_BYTE;
                phy_val_d = 1'b1;
                crc_d     = '1;
                len_d     = '0;
                state_d   = S_PAY;
            end

            S_PAY: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    phy_dat_d = in_dat;
                    phy_val_d = 1'b1;
                    crc_d     = crc_byte(crc_q, in_dat);
                    len_d     = len_inc;
                    if (in_lst) begin
                        cnt_d = '0;
`ifdef QNIGMA_MAC_TX_PAD_EN
                        if (len_inc < MIN_LEN) state_d = S_PAD;
                        else                   state_d = S_FCS;
`else
                        state_d = S_FCS;
`endif
                    end
                end else begin
                    // Underrun: line goes quiet next cycle, rest of frame is dropped.
                    err_d   = 1'b1;
                    state_d = S_DROP;
                end
            end

`ifdef QNIGMA_MAC_TX_PAD_EN
            S_PAD: begin
                phy_dat_d = 8'h00;
                phy_val_d = 1'b1;
                crc_d     = crc_byte(crc_q, 8'h00);
                len_d     = len_inc;
                if (len_inc >= MIN_LEN) begin
                    state_d = S_FCS;
                    cnt_d   = '0;
                end
            end
`endif

            S_FCS: begin
                phy_val_d = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    phy_dat_d = fcs[7:0];
                    2'd1:    phy_dat_d = fcs[15:8];
                    2'd2:    phy_dat_d = fcs[23:16];
                    default: phy_dat_d = fcs[31:24];
                endcase
                if (cnt_q == FCS_LAST) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_DROP: begin
                in_rdy = 1'b1;
                if (in_val && in_lst) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: doc/qnigma_mac_tx.md
QNIGMA_MAC_TX -- requirements
Module: qnigma_mac_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk  input  1  rising-edge clock for all logic.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port in_dat  input  8  payload byte from upstream.
REQ-005 Port in_val  input  1  in_dat valid.
REQ-006 Port in_lst  input  1  marks the last payload byte of the frame; qualified by in_val.
REQ-007 Port in_rdy  output  1  block accepts in_dat this cycle; a byte transfers when in_val and in_rdy are both high.
REQ-008 Port phy_dat  output  8  byte to the PHY/GMII.
REQ-009 Port phy_val  output  1  phy_dat valid (GMII TX_EN).
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port err  output  1  one-cycle pulse on payload underrun.

Function
REQ-012 States SHALL be IDLE, PRE, SFD, PAY, PAD, FCS, IFG and DROP.
REQ-013 IDLE: on in_val=1, go to PRE; in_rdy=0; the first byte is held upstream.
REQ-014 PRE: emit 0x55 for 7 cycles, then go to SFD; SFD: emit 0xD5 for 1 cycle, then go to PAY.
REQ-015 PAY: in_rdy=1; each accepted byte appears on phy_dat with phy_val=1 exactly one cycle after the handshake (registered outputs).
REQ-016 PAY underrun: in_val=0 before in_lst SHALL force phy_val=0 next cycle and pulse err; go to DROP.
REQ-017 DROP: in_rdy=1; discard bytes until in_lst is accepted, then go to IFG; emit nothing.
REQ-018 CRC32: reflected polynomial 0xEDB88320, LSB-first, one byte per cycle; initialise to 0xFFFFFFFF in SFD; update on every payload and pad byte.
REQ-019 FCS: transmit ~crc as 4 bytes in 4 consecutive cycles, bits [7:0] first and [31:24] last, then go to IFG.
REQ-020 Byte counter: 6 bits, counts payload plus pad bytes, saturates at 60, cleared in SFD.
REQ-021 IFG: phy_val=0 and in_rdy=0 for 12 cycles, then go to IDLE; in_val during IFG is ignored.
REQ-022 phy_val SHALL be continuous from the first preamble byte to the last FCS byte for non-aborted frames.
REQ-023 A frame with in_lst on its first byte is legal.
REQ-024 When phy_val=0, phy_dat SHALL be 0x00.

Reset
REQ-025 On rst=1: state=IDLE; phy_val=0; phy_dat=0x00; in_rdy=0; busy=0; err=0; crc=0xFFFFFFFF; all counters=0; all take effect on the next clock edge.
REQ-026 Reset mid-frame SHALL truncate output immediately (phy_val=0 the next cycle); no FCS is emitted.

Configuration
REQ-027 Macro QNIGMA_MAC_TX_PAD_EN defined: after in_lst, if byte count <60, go to PAD and emit 0x00 bytes (included in the CRC) until the count reaches 60, then go to FCS.
REQ-028 Macro undefined: the PAD state is absent; PAY goes directly to FCS; frames shorter than 60 bytes are sent unpadded.

Verification
REQ-029 No-pad build, payload "123456789" (0x31..0x39) -> 7x0x55, 0xD5, 9 payload bytes, then FCS bytes 0x26 0x39 0xF4 0xCB; phy_val high for 21 cycles.
REQ-030 Pad build, 1-byte payload 0xAA -> phy_val high for 72 cycles (8+60+4); bytes 2..60 after SFD are 0x00; post-SFD bytes run through the CRC32 receive checker leave residue 0xDEBB20E3.
REQ-031 Underrun: in_val drops after the 3rd payload byte -> err pulse, phy_val=0 the next cycle; bytes until in_lst are consumed with no output; 12 idle cycles follow.
REQ-032 Back-to-back: two 64-byte frames with in_val held high -> exactly 12 phy_val=0 cycles between the last FCS byte and the next 0x55.
REQ-033 rst asserted during the 5th FCS-phase or payload cycle -> phy_val=0, busy=0, in_rdy=0 the next cycle; the next frame starts with a full preamble and correct FCS.
